// File: rtl/bridge_burst_source.sv
// bridge_burst_source: clka-side FIFO plus burst transmitter answering the bridge's stretched request.
// Bursts are capped at BURST_LEN so the bridge's flagless 16-entry FIFO cannot overflow.
module bridge_burst_source #(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 8,
    parameter int STALL_MAX = 16
) (
    input  logic                     clka,
    input  logic                     reset_clka,
    input  logic                     push_clka,
    input  logic [7:0]               push_data_clka,
    output logic                     full_clka,
    output logic [$clog2(DEPTH):0]   level_clka,
    input  logic                     data_req_clka,
    output logic                     data_valid_clka,
    output logic [7:0]               tx_data_clka,
    output logic                     burst_done_clka,
    output logic                     burst_abort_clka
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [3:0] SENT_END = 4'(BURST_LEN);
    localparam logic [SW-1:0] STALL_END = SW'(STALL_MAX);

    typedef enum logic [1:0] {IDLE, BURST, WAIT_LOW} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [3:0]    sent_q, sent_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          valid_q, valid_d, done_q, done_d, abort_q, abort_d;
    logic [7:0]    data_q, data_d;
    logic          empty, push_ok, pop;

    assign level_clka       = wr_ptr_q - rd_ptr_q;
    assign full_clka        = level_clka == FULL_LVL;
    assign empty            = wr_ptr_q == rd_ptr_q;
    assign push_ok          = push_clka && !full_clka;
    // pop is gated by the registered empty flag, so a fresh push is never bypassed
    assign pop              = state_q == BURST && !empty;
    assign data_valid_clka  = valid_q;
    assign tx_data_clka     = data_q;
    assign burst_done_clka  = done_q;
    assign burst_abort_clka = abort_q;

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        stall_d = stall_q;
        valid_d = pop;
        data_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : data_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_clka) begin
                    state_d = BURST;
                    sent_d  = '0;
                    stall_d = '0;
                end
            end
            BURST: begin
                if (pop) begin
                    sent_d  = (sent_q == SENT_END) ? sent_q : sent_q + 1'b1;
                    stall_d = '0;
                    if (sent_d == SENT_END) begin
                        done_d  = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end else begin
                    stall_d = (stall_q == STALL_END) ? stall_q : stall_q + 1'b1;
                    if (stall_d == STALL_END) begin
                        abort_d = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: state_d = data_req_clka ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_clka) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            stall_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_clka;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bridge_burst_source.sv
// tb_bridge_burst_source: directed scenarios plus random traffic against a queue-based reference model.
module tb_bridge_burst_source;
    localparam int DEPTH = 8;
    localparam int BL    = 8;
    localparam int SM    = 16;

    logic       clka = 1'b0;
    logic       reset_clka = 1'b1;
    logic       push_clka = 1'b0;
    logic [7:0] push_data_clka = 8'h00;
    logic       data_req_clka = 1'b0;
    logic       full_clka, data_valid_clka, burst_done_clka, burst_abort_clka;
    logic [3:0] level_clka;
    logic [7:0] tx_data_clka;

    bridge_burst_source #(.DEPTH(DEPTH), .BURST_LEN(BL), .STALL_MAX(SM)) dut (
        .clka(clka), .reset_clka(reset_clka), .push_clka(push_clka),
        .push_data_clka(push_data_clka), .full_clka(full_clka), .level_clka(level_clka),
        .data_req_clka(data_req_clka), .data_valid_clka(data_valid_clka),
        .tx_data_clka(tx_data_clka), .burst_done_clka(burst_done_clka),
        .burst_abort_clka(burst_abort_clka)
    );

    always #5 clka = ~clka;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: a byte queue plus "how far into the burst" counters
    byte unsigned mq[$];
    bit   m_active, m_hold, started, do_pop, do_push;
    int   m_sent, m_stall;
    bit   e_valid, e_done, e_abort;
    logic [7:0] e_data = 8'h00;

    always @(posedge clka) begin
        started = 1'b1;
        if (reset_clka) begin
            mq.delete();
            m_active = 0; m_hold = 0; m_sent = 0; m_stall = 0;
            e_valid = 0; e_done = 0; e_abort = 0; e_data = 8'h00;
        end else begin
            do_pop  = m_active && mq.size() > 0;
            do_push = push_clka && mq.size() < DEPTH;
            e_valid = do_pop; e_done = 0; e_abort = 0;
            if (do_pop) begin
                e_data = mq.pop_front();
                m_sent++; m_stall = 0;
                if (m_sent == BL) begin m_active = 0; m_hold = 1; e_done = 1; end
            end else if (m_active) begin
                m_stall++;
                if (m_stall == SM) begin m_active = 0; m_hold = 1; e_abort = 1; end
            end else if (m_hold) begin
                m_hold = data_req_clka;
            end else if (data_req_clka) begin
                m_active = 1; m_sent = 0; m_stall = 0;
            end
            if (do_push) mq.push_back(push_data_clka);
        end
    end

    byte unsigned cap[$];
    int n_done = 0, n_abort = 0;

    always @(negedge clka) begin
        if (started) begin
            chk("valid", data_valid_clka, e_valid);
            chk("done", burst_done_clka, e_done);
            chk("abort", burst_abort_clka, e_abort);
            chk("level", level_clka, mq.size());
            chk("full", full_clka, mq.size() == DEPTH);
            if (e_valid) chk("data", tx_data_clka, e_data);
            if (data_valid_clka) cap.push_back(tx_data_clka);
            if (burst_done_clka) n_done++;
            if (burst_abort_clka) n_abort++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clka); #1; end
    endtask

    task automatic push_byte(logic [7:0] d);
        push_clka = 1'b1; push_data_clka = d; tick(); push_clka = 1'b0;
    endtask

    task automatic clear_obs();
        cap.delete(); n_done = 0; n_abort = 0;
    endtask

    function automatic void chk_cap(string name, byte unsigned exp[$]);
        chk({name, "_count"}, cap.size(), exp.size());
        foreach (exp[i]) if (i < cap.size()) chk(name, cap[i], exp[i]);
    endfunction

    initial begin
        byte unsigned exp[$];
        int nv;
        // 1: reset held with pushes active
        push_clka = 1'b1; push_data_clka = 8'h3C;
        tick(2);
        reset_clka = 1'b0; push_clka = 1'b0;
        chk("t1_level", level_clka, 0);
        chk("t1_full", full_clka, 0);
        chk("t1_valid", data_valid_clka, 0);
        chk("t1_done", burst_done_clka, 0);
        chk("t1_abort", burst_abort_clka, 0);
        // 2: full burst from a primed FIFO, request held long
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        clear_obs();
        data_req_clka = 1'b1; tick(23); data_req_clka = 1'b0; tick(3);
        exp = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        chk_cap("t2_byte", exp);
        chk("t2_done_pulses", n_done, 1);
        chk("t2_aborts", n_abort, 0);
        // 3: overflow drops the last two bytes
        for (int i = 0; i < 10; i++) push_byte(8'hA0 + 8'(i));
        chk("t3_level", level_clka, 8);
        chk("t3_full", full_clka, 1);
        clear_obs();
        data_req_clka = 1'b1; tick(12); data_req_clka = 1'b0; tick(3);
        exp = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        chk_cap("t3_byte", exp);
        chk("t3_done_pulses", n_done, 1);
        // 4: stall timeout, then a WAIT_LOW push waits for the next request
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        clear_obs();
        data_req_clka = 1'b1; tick(25);
        push_byte(8'h55); tick(3);
        exp = {8'hC0, 8'hC1, 8'hC2};
        chk_cap("t4_byte", exp);
        chk("t4_aborts", n_abort, 1);
        chk("t4_done_pulses", n_done, 0);
        data_req_clka = 1'b0; tick(2);
        clear_obs();
        data_req_clka = 1'b1; tick(22); data_req_clka = 1'b0; tick(2);
        exp = {8'h55};
        chk_cap("t4_late_byte", exp);
        chk("t4_late_aborts", n_abort, 1);
        // 5: push on every popping cycle keeps the level flat
        for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
        clear_obs();
        data_req_clka = 1'b1; tick();
        push_clka = 1'b1;
        for (int i = 0; i < 8; i++) begin push_data_clka = 8'hE0 + 8'(i); tick(); end
        push_clka = 1'b0; tick();
        chk("t5_level", level_clka, 4);
        exp = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1, 8'hE2, 8'hE3};
        chk_cap("t5_byte", exp);
        chk("t5_done_pulses", n_done, 1);
        data_req_clka = 1'b0; tick(2);
        for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
        chk("t5_full", full_clka, 1);
        clear_obs();
        data_req_clka = 1'b1; push_clka = 1'b1; push_data_clka = 8'h77; tick(2); push_clka = 1'b0;
        chk("t5_full_pop_level", level_clka, 7);
        tick(25); data_req_clka = 1'b0; tick(2);
        exp = {8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'h60, 8'h61, 8'h62, 8'h63};
        chk_cap("t5_full_byte", exp);
        // 6: reset mid-burst
        for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i));
        data_req_clka = 1'b1;
        nv = 0;
        for (int i = 0; i < 20 && nv < 3; i++) begin tick(); if (data_valid_clka) nv++; end
        chk("t6_saw_three_valids", nv, 3);
        reset_clka = 1'b1; tick(); reset_clka = 1'b0;
        chk("t6_level", level_clka, 0);
        chk("t6_valid", data_valid_clka, 0);
        clear_obs();
        tick(4);
        chk("t6_no_data", cap.size(), 0);
        push_byte(8'h99); tick(4);
        exp = {8'h99};
        chk_cap("t6_byte", exp);
        tick(20); data_req_clka = 1'b0; tick(3);
        // random traffic, rare resets
        for (int i = 0; i < 4000; i++) begin
            push_clka = ($urandom_range(0, 9) < 4);
            push_data_clka = 8'($urandom);
            if ($urandom_range(0, 15) == 0) data_req_clka = ~data_req_clka;
            reset_clka = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset_clka = 1'b0; push_clka = 1'b0; data_req_clka = 1'b0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
